pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Program-counter control unit for the 16-bit CPU front end. Owns the PC register and selects the next PC each cycle from: sequential increment (+2), PC-relative branch, register branch, hold (stall) or freeze (halt). Generates the fetch-valid and front-end flush signals consumed by the IF/ID pipeline register. Sits between instruction memory, the hazard unit and the branch-resolution logic.

Parameters:
WIDTH, 16, PC and address width in bits.
RESET_PC, 16'h0000, PC value loaded on reset.
IMM_W, 9, width of signed branch word-offset immediate.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
stall  input  1  hazard unit hold request; PC does not advance.
br_taken  input  1  PC-relative branch resolved taken this cycle.
br_imm  input  IMM_W  signed word offset of taken branch.
br_base  input  WIDTH  PC+2 of the branching instruction.
br_reg  input  1  register-indirect branch resolved this cycle.
reg_target  input  WIDTH  register value for br_reg.
halt_in  input  1  HLT decoded.
pc  output  WIDTH  current fetch address.
pc_plus2  output  WIDTH  pc + 2, mod 2^WIDTH (combinational).
fetch_valid  output  1  instruction at pc is fetched this cycle.
flush  output  1  squash IF/ID contents.
halted  output  1  sequencer in HALT state.
wrap  output  1  sticky: PC has wrapped 0xFFFE -> 0x0000.

Behaviour:
- Async reset (rst_n=0): pc=RESET_PC, state=RUN, flush=0, halted=0, wrap=0. Effective immediately, regardless of clk or current operation.
- States: RUN, HALT. halted = (state==HALT), registered.
- Next-PC priority in RUN, evaluated each rising edge:
  1. br_reg: pc <= {reg_target[WIDTH-1:1], 1'b0}. Bit 0 is forced to 0.
  2. br_taken: pc <= br_base + (sign_ext(br_imm) << 1), mod 2^WIDTH.
  3. halt_in: pc holds; state -> HALT.
  4. stall: pc holds.
  5. else: pc <= pc_plus2.
- br_reg and br_taken together: br_reg wins.
- A redirect (1 or 2) overrides a concurrent stall and halt_in. The branch is older than the stalled or halting instruction, so a HLT being flushed does not halt.
- flush: registered. It is 1 for the cycle after any accepted redirect; otherwise 0. Back-to-back redirects keep flush high continuously.
- fetch_valid = (state==RUN) & ~stall & ~halt_in, combinational.
- HALT: pc frozen; all inputs ignored; flush=0; fetch_valid=0. Only reset exits HALT.
- wrap: set when the sequential increment takes pc from 0xFFFE to 0x0000. Redirect targets that cross zero do not set it. Cleared only by reset.
- Arithmetic: all adds truncate to WIDTH bits, with no overflow trap. The immediate sign-extends from bit IMM_W-1.
- Latency: one cycle from a redirect input to the new pc; one cycle from halt_in to halted=1.
- Odd-address behaviour: br_base and RESET_PC are assumed even. pc bit 0 is never set by the sequencer itself.
- Reset asserted mid-stall, mid-redirect or in HALT: outputs return to reset values asynchronously. The first post-reset edge performs a normal RUN evaluation.

Test Plan:
- Reset then free-run 4 cycles -> pc 0x0000, 0x0002, 0x0004, 0x0006; fetch_valid=1; flush=0.
- From pc=0x0010: br_taken=1, br_base=0x0012, br_imm=9'h1FC (-4) -> next pc=0x000A; flush=1 exactly one cycle.
- stall=1 for 3 cycles at pc=0x0020 -> pc holds 0x0020 and fetch_valid=0; on release pc=0x0022. In the same run, stall+br_reg with reg_target=0x1235 -> pc=0x1234, flush=1.
- halt_in at pc=0x0040 -> halted=1 next cycle, pc stays 0x0040. Later br_taken, stall and halt_in toggles -> no change. Assert rst_n=0 mid-cycle -> pc=0x0000 and halted=0 immediately.
- halt_in and br_taken (target 0x0100) in the same cycle -> pc=0x0100, state remains RUN, flush=1.
- RESET_PC=16'hFFFC: free-run -> 0xFFFC, 0xFFFE, 0x0000 with wrap=1 sticky. Then br_taken to 0xFFFE and run -> wrap remains 1; no other flag changes.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter control for the 16-bit CPU front end.
// Owns the PC register, picks the next fetch address each cycle and drives
// fetch_valid / flush toward the IF/ID pipeline register.
//
// Interface semantics: fetch_valid is a one-cycle qualifier with no ready
// side. When high, the instruction at pc is fetched this cycle. When low
// (stall, halt request or HALT state), IF/ID must not capture a new word.
// flush is registered. It is high for the cycle after a taken redirect so
// that the wrong-path word fetched during the redirect cycle is squashed.
module pc_sequencer #(
  parameter int unsigned            WIDTH    = 16,
  parameter logic [WIDTH-1:0]       RESET_PC = 16'h0000,
  parameter int unsigned            IMM_W    = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [IMM_W-1:0] br_imm,
  input  logic [WIDTH-1:0] br_base,
  input  logic             br_reg,
  input  logic [WIDTH-1:0] reg_target,
  input  logic             halt_in,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus2,
  output logic             fetch_valid,
  output logic             flush,
  output logic             halted,
  output logic             wrap
);

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_HALT = 1'b1;

  // Last even address; the sequential step from here wraps to zero.
  localparam logic [WIDTH-1:0] PC_TOP   = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] EVEN_MSK = {{(WIDTH-1){1'b1}}, 1'b0};

  logic             state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             flush_q, flush_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] reg_dest;
  logic             running;

  // Target arithmetic: word offset sign-extended, scaled to bytes and added modulo 2^WIDTH.
  always_comb begin
    imm_ext   = {{(WIDTH-IMM_W){br_imm[IMM_W-1]}}, br_imm};
    br_target = br_base + (imm_ext << 1);
    reg_dest  = reg_target & EVEN_MSK;
    pc_plus2  = pc_q + WIDTH'(2);
    running   = (state_q == ST_RUN);
  end

  // Next-state selection: register branch, relative branch, halt, stall, increment.
  // A redirect outranks halt_in because the HLT is on the squashed wrong path.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    wrap_d  = wrap_q;
    if (running) begin
      if (br_reg) begin
        pc_d    = reg_dest;
        flush_d = 1'b1;
      end else if (br_taken) begin
        pc_d    = br_target;
        flush_d = 1'b1;
      end else if (halt_in) begin
        state_d = ST_HALT;
      end else if (!stall) begin
        pc_d = pc_plus2;
        if (pc_q == PC_TOP) begin
          wrap_d = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      wrap_q  <= wrap_d;
    end
  end

  // Output drive: registered flags plus the combinational fetch qualifier.
  always_comb begin
    pc          = pc_q;
    flush       = flush_q;
    wrap        = wrap_q;
    halted      = (state_q == ST_HALT);
    fetch_valid = running & ~stall & ~halt_in;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: one default instance and one with RESET_PC=0xFFFC,
// both driven from the same stimulus, each with its own reference model and
// expected queue.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall, br_taken, br_reg, halt_in;
  logic [8:0]  br_imm;
  logic [15:0] br_base, reg_target;

  logic [15:0] pc_a, pc2_a, pc_b, pc2_b;
  logic        fv_a, fl_a, ht_a, wr_a;
  logic        fv_b, fl_b, ht_b, wr_b;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic        halted;
    logic        flush;
    logic        wrap;
  } mst_t;

  mst_t m_a, m_b;
  logic [18:0] exp_q[$];
  logic [18:0] exp_w_q[$];

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_imm(br_imm), .br_base(br_base), .br_reg(br_reg),
    .reg_target(reg_target), .halt_in(halt_in), .pc(pc_a),
    .pc_plus2(pc2_a), .fetch_valid(fv_a), .flush(fl_a),
    .halted(ht_a), .wrap(wr_a)
  );

  pc_sequencer #(.RESET_PC(16'hFFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_imm(br_imm), .br_base(br_base), .br_reg(br_reg),
    .reg_target(reg_target), .halt_in(halt_in), .pc(pc_b),
    .pc_plus2(pc2_b), .fetch_valid(fv_b), .flush(fl_b),
    .halted(ht_b), .wrap(wr_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference behaviour of one rising edge
  function automatic mst_t model_next(input mst_t m, input logic s,
      input logic bt, input logic br, input logic h, input logic [8:0] imm,
      input logic [15:0] base, input logic [15:0] rt);
    mst_t n;
    n = m;
    n.flush = 1'b0;
    if (!m.halted) begin
      if (br) begin
        n.pc = {rt[15:1], 1'b0};
        n.flush = 1'b1;
      end else if (bt) begin
        n.pc = base + {{6{imm[8]}}, imm, 1'b0};
        n.flush = 1'b1;
      end else if (h) begin
        n.halted = 1'b1;
      end else if (!s) begin
        n.pc = m.pc + 16'd2;
        if (m.pc == 16'hFFFE) n.wrap = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic compare_state(input string who, input logic [18:0] e,
      input logic [15:0] p, input logic [15:0] p2, input logic h,
      input logic f, input logic w);
    check_val({who, "_pc"}, {16'd0, p}, {16'd0, e[18:3]});
    check_val({who, "_pc_plus2"}, {16'd0, p2}, {16'd0, e[18:3] + 16'd2});
    check_val({who, "_halted"}, {31'd0, h}, {31'd0, e[2]});
    check_val({who, "_flush"}, {31'd0, f}, {31'd0, e[1]});
    check_val({who, "_wrap"}, {31'd0, w}, {31'd0, e[0]});
  endtask

  // Driver: apply one cycle of inputs, check fetch_valid, then score the edge
  task automatic step(input logic s, input logic bt, input logic br,
      input logic h, input logic [8:0] imm, input logic [15:0] base,
      input logic [15:0] rt);
    logic [18:0] e;
    stall = s; br_taken = bt; br_reg = br; halt_in = h;
    br_imm = imm; br_base = base; reg_target = rt;
    #1;
    check_val("fetch_valid_a", {31'd0, fv_a}, {31'd0, !m_a.halted && !s && !h});
    check_val("fetch_valid_b", {31'd0, fv_b}, {31'd0, !m_b.halted && !s && !h});
    m_a = model_next(m_a, s, bt, br, h, imm, base, rt);
    m_b = model_next(m_b, s, bt, br, h, imm, base, rt);
    exp_q.push_back(m_a);
    exp_w_q.push_back(m_b);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) check_val("sb_a_empty", 32'd0, 32'd1);
    else begin
      e = exp_q.pop_front();
      compare_state("a", e, pc_a, pc2_a, ht_a, fl_a, wr_a);
    end
    if (exp_w_q.size() == 0) check_val("sb_b_empty", 32'd0, 32'd1);
    else begin
      e = exp_w_q.pop_front();
      compare_state("b", e, pc_b, pc2_b, ht_b, fl_b, wr_b);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 16'h0000, 16'h0000);
  endtask

  task automatic model_reset();
    m_a = '{pc: 16'h0000, halted: 1'b0, flush: 1'b0, wrap: 1'b0};
    m_b = '{pc: 16'hFFFC, halted: 1'b0, flush: 1'b0, wrap: 1'b0};
    exp_q.delete();
    exp_w_q.delete();
  endtask

  // Assert reset away from an edge, check asynchronous effect, release on negedge
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val({tag, "_pc_a"}, {16'd0, pc_a}, 32'h0000);
    check_val({tag, "_pc_b"}, {16'd0, pc_b}, 32'hFFFC);
    check_val({tag, "_halted"}, {30'd0, ht_a, ht_b}, 32'd0);
    check_val({tag, "_flush"}, {30'd0, fl_a, fl_b}, 32'd0);
    check_val({tag, "_wrap"}, {30'd0, wr_a, wr_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to(input logic [15:0] target);
    for (int i = 0; i < 64 && m_a.pc != target; i++) idle();
    check_val("run_to_pc", {16'd0, pc_a}, {16'd0, target});
  endtask

  initial begin
    logic [15:0] rb, rr;
    logic [8:0]  ri;
    logic        rs, rt_, rg;
    rst_n = 1'b1;
    stall = 0; br_taken = 0; br_reg = 0; halt_in = 0;
    br_imm = '0; br_base = '0; reg_target = '0;
    model_reset();
    @(negedge clk);
    do_reset("reset0");

    // Free-run from reset: 0, 2, 4, 6
    check_val("run_pc0", {16'd0, pc_a}, 32'h0000);
    idle(); check_val("run_pc1", {16'd0, pc_a}, 32'h0002);
    idle(); check_val("run_pc2", {16'd0, pc_a}, 32'h0004);
    idle(); check_val("run_pc3", {16'd0, pc_a}, 32'h0006);

    // Relative branch backward by 4 words from 0x0010
    run_to(16'h0010);
    step(1'b0, 1'b1, 1'b0, 1'b0, 9'h1FC, 16'h0012, 16'h0000);
    check_val("tp_branch_pc", {16'd0, pc_a}, 32'h000A);
    check_val("tp_branch_flush", {31'd0, fl_a}, 32'd1);
    idle();
    check_val("tp_branch_flush_drop", {31'd0, fl_a}, 32'd0);

    // Back-to-back redirects hold flush high
    step(1'b0, 1'b1, 1'b0, 1'b0, 9'h004, 16'h0010, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 16'h0000, 16'h0301);
    check_val("b2b_pc", {16'd0, pc_a}, 32'h0300);
    check_val("b2b_flush", {31'd0, fl_a}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 9'h010, 16'h0400, 16'h0000);
    check_val("reg_wins_pc", {16'd0, pc_a}, 32'h0000);
    idle();

    // Stall for three cycles at 0x0020, then stall with register branch
    run_to(16'h0020);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 16'h0000, 16'h0000);
    check_val("stall_hold_pc", {16'd0, pc_a}, 32'h0020);
    idle();
    check_val("stall_release_pc", {16'd0, pc_a}, 32'h0022);
    step(1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 16'h0000, 16'h1235);
    check_val("stall_brreg_pc", {16'd0, pc_a}, 32'h1234);
    check_val("stall_brreg_flush", {31'd0, fl_a}, 32'd1);
    idle();

    // Halt request coincident with a taken branch: branch wins
    step(1'b0, 1'b1, 1'b0, 1'b1, 9'h008, 16'h00F0, 16'h0000);
    check_val("halt_br_pc", {16'd0, pc_a}, 32'h0100);
    check_val("halt_br_state", {31'd0, ht_a}, 32'd0);
    idle();

    // Randomised traffic without halt requests
    for (int i = 0; i < 40; i++) begin
      rs  = 1'($urandom_range(0, 3) == 0);
      rt_ = 1'($urandom_range(0, 4) == 0);
      rg  = 1'($urandom_range(0, 6) == 0);
      ri  = 9'($urandom_range(0, 511));
      rb  = 16'($urandom_range(0, 65535)) & 16'hFFFE;
      rr  = 16'($urandom_range(0, 65535));
      step(rs, rt_, rg, 1'b0, ri, rb, rr);
    end

    // Halt at 0x0040, then ignore every input
    step(1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 16'h0000, 16'h0040);
    step(1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 16'h0000, 16'h0000);
    check_val("halt_pc", {16'd0, pc_a}, 32'h0040);
    check_val("halt_state", {31'd0, ht_a}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 16'h0200, 16'h0300);
    end
    check_val("halt_frozen_pc", {16'd0, pc_a}, 32'h0040);
    check_val("halt_frozen_flush", {31'd0, fl_a}, 32'd0);
    do_reset("reset_in_halt");

    // Wrap from 0xFFFC reset value
    idle();
    check_val("wrap_pc_fffe", {16'd0, pc_b}, 32'hFFFE);
    check_val("wrap_not_yet", {31'd0, wr_b}, 32'd0);
    idle();
    check_val("wrap_pc_0000", {16'd0, pc_b}, 32'h0000);
    check_val("wrap_set", {31'd0, wr_b}, 32'd1);
    idle();
    step(1'b0, 1'b1, 1'b0, 1'b0, 9'h1FF, 16'h0000, 16'h0000);
    check_val("wrap_br_pc", {16'd0, pc_b}, 32'hFFFE);
    check_val("wrap_sticky", {31'd0, wr_b}, 32'd1);
    check_val("wrap_a_clear", {31'd0, wr_a}, 32'd0);
    idle();
    idle();
    check_val("wrap_run_halted", {30'd0, ht_a, ht_b}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
